// File: rtl/cube_projector.sv
// cube_projector: collects a 24-beat burst of camera-space cube vertices,
// projects each vertex onto the image plane with fixed intrinsics using a
// serial restoring divider, and publishes the projected cube only on a
// video frame boundary so the overlay never tears mid-frame.
module cube_projector #(
  parameter int unsigned FX    = 721,
  parameter int unsigned FY    = 721,
  parameter int          CX    = 609,
  parameter int          CY    = 172,
  parameter int          MAX_X = 1226,
  parameter int          MAX_Y = 370,
  parameter logic [31:0] ZMIN  = 32'h0000_1000
) (
  input  logic             s00_axis_aclk,
  input  logic             s00_axis_areset,
  input  logic [31:0]      s00_axis_tdata,
  input  logic             s00_axis_tvalid,
  input  logic             s00_axis_tlast,
  output logic             s00_axis_tready,
  input  logic             frame_end,
  output logic [7:0][31:0] cube_pts,
  output logic             cube_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DROP,
    ST_MUL,
    ST_DIVX,
    ST_DIVY,
    ST_STORE,
    ST_WAIT,
    ST_COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       beatCnt_q, beatCnt_d;
  logic [2:0]       vtx_q, vtx_d;
  logic [5:0]       divCnt_q, divCnt_d;
  logic             reject_q, reject_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [31:0]      coord_q [24];
  logic [31:0]      coord_d [24];
  logic [7:0][31:0] shadow_q, shadow_d;
  logic [7:0][31:0] pts_q, pts_d;
  logic [47:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic [47:0]      magY_q, magY_d;
  logic [47:0]      qx_q, qx_d;
  logic [47:0]      qy_q, qy_d;
  logic             signX_q, signX_d;
  logic             signY_q, signY_d;

  logic               beat;
  logic [4:0]         baseIdx;
  logic [31:0]        xIn, yIn, zIn;
  logic signed [47:0] xExt, yExt, fxExt, fyExt;
  logic signed [47:0] px, py;
  logic [47:0]        absPx, absPy;
  logic               zTooSmall;
  logic [32:0]        remShift;
  logic [31:0]        remDiff, remNext;
  logic               remGe;
  logic [47:0]        quotNext;

  // Saturate the quotient magnitude, apply its sign around the principal
  // point, then clamp into the visible image range.
  function automatic logic [10:0] clampAxis(input logic [47:0] q, input logic neg,
                                            input int c, input int maxv);
    int mag;
    int v;
    mag = (q >= 48'd1048576) ? 1048576 : int'({12'd0, q[19:0]});
    v = neg ? (c - mag) : (c + mag);
    if (v < 0) v = 0;
    else if (v > maxv - 1) v = maxv - 1;
    return 11'(v);
  endfunction

  assign beat    = s00_axis_tvalid && s00_axis_tready;
  assign baseIdx = {2'b00, vtx_q} + {1'b0, vtx_q, 1'b0};
  assign xIn     = coord_q[baseIdx];
  assign yIn     = coord_q[baseIdx + 5'd1];
  assign zIn     = coord_q[baseIdx + 5'd2];

  assign xExt  = {{16{xIn[31]}}, xIn};
  assign yExt  = {{16{yIn[31]}}, yIn};
  assign fxExt = 48'(FX);
  assign fyExt = 48'(FY);
  assign px    = xExt * fxExt;
  assign py    = yExt * fyExt;
  assign absPx = px[47] ? 48'(-px) : 48'(px);
  assign absPy = py[47] ? 48'(-py) : 48'(py);

  assign zTooSmall = $signed(zIn) < $signed(ZMIN);

  // One restoring-division step: shift in the next dividend bit and subtract
  // Z when it fits, shifting the quotient bit into the dividend register.
  assign remShift = {rem_q, quot_q[47]};
  assign remGe    = remShift >= {1'b0, zIn};
  assign remDiff  = remShift[31:0] - zIn;
  assign remNext  = remGe ? remDiff : remShift[31:0];
  assign quotNext = {quot_q[46:0], remGe};

  // State and datapath registers; reset returns everything to idle and empty.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q   <= ST_IDLE;
      beatCnt_q <= '0;
      vtx_q     <= '0;
      divCnt_q  <= '0;
      reject_q  <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      coord_q   <= '{default: '0};
      shadow_q  <= '0;
      pts_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      magY_q    <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      signX_q   <= 1'b0;
      signY_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      vtx_q     <= vtx_d;
      divCnt_q  <= divCnt_d;
      reject_q  <= reject_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      coord_q   <= coord_d;
      shadow_q  <= shadow_d;
      pts_q     <= pts_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      magY_q    <= magY_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      signX_q   <= signX_d;
      signY_q   <= signY_d;
    end
  end

  // Next-state logic: burst framing, per-vertex multiply/divide/store
  // sequencing, and the frame-aligned commit of the shadow cube.
  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    vtx_d     = vtx_q;
    divCnt_d  = divCnt_q;
    reject_d  = reject_q;
    err_d     = 1'b0;
    valid_d   = valid_q;
    coord_d   = coord_q;
    shadow_d  = shadow_q;
    pts_d     = pts_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    magY_d    = magY_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    signX_d   = signX_q;
    signY_d   = signY_q;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          coord_d[0] = s00_axis_tdata;
          if (s00_axis_tlast) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            beatCnt_d = 5'd1;
          end
        end
      end
      ST_LOAD: begin
        if (beat) begin
          coord_d[beatCnt_q] = s00_axis_tdata;
          beatCnt_d = beatCnt_q + 5'd1;
          if (beatCnt_q == 5'd23) begin
            if (s00_axis_tlast) begin
              state_d  = ST_MUL;
              vtx_d    = '0;
              reject_d = 1'b0;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end
          end else if (s00_axis_tlast) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (beat && s00_axis_tlast) state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (zTooSmall) reject_d = 1'b1;
        quot_d   = absPx;
        rem_d    = '0;
        magY_d   = absPy;
        signX_d  = px[47];
        signY_d  = py[47];
        divCnt_d = '0;
        state_d  = ST_DIVX;
      end
      ST_DIVX: begin
        quot_d   = quotNext;
        rem_d    = remNext;
        divCnt_d = divCnt_q + 6'd1;
        if (divCnt_q == 6'd47) begin
          qx_d     = quotNext;
          quot_d   = magY_q;
          rem_d    = '0;
          divCnt_d = '0;
          state_d  = ST_DIVY;
        end
      end
      ST_DIVY: begin
        quot_d   = quotNext;
        rem_d    = remNext;
        divCnt_d = divCnt_q + 6'd1;
        if (divCnt_q == 6'd47) begin
          qy_d     = quotNext;
          divCnt_d = '0;
          state_d  = ST_STORE;
        end
      end
      ST_STORE: begin
        shadow_d[vtx_q] = {5'd0, clampAxis(qy_q, signY_q, CY, MAX_Y),
                           5'd0, clampAxis(qx_q, signX_q, CX, MAX_X)};
        vtx_d = vtx_q + 3'd1;
        if (vtx_q == 3'd7) begin
          if (reject_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_WAIT: begin
        if (frame_end) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        pts_d   = shadow_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    s00_axis_tready = 1'b0;
    busy            = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD, ST_DROP: s00_axis_tready = 1'b1;
      default:                   s00_axis_tready = 1'b0;
    endcase
    case (state_q)
      ST_LOAD, ST_MUL, ST_DIVX, ST_DIVY, ST_STORE, ST_WAIT: busy = 1'b1;
      default:                                               busy = 1'b0;
    endcase
  end

  assign cube_pts   = pts_q;
  assign cube_valid = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cube_projector.sv
// Bench for cube_projector: random and directed cubes are driven over the
// stream port; each cube's outcome (commit with projected points, or error)
// is predicted from plain pinhole arithmetic and queued, and an independent
// monitor pops and compares whenever the DUT commits or pulses err.
module tb_cube_projector;

  localparam int FX    = 721;
  localparam int FY    = 721;
  localparam int CX    = 609;
  localparam int CY    = 172;
  localparam int MAX_X = 1226;
  localparam int MAX_Y = 370;
  localparam int ZMIN  = 32'h0000_1000;

  typedef int cube_t [24];
  typedef struct {
    bit               isErr;
    logic [7:0][31:0] pts;
  } exp_t;

  logic             clk = 1'b0;
  logic             areset;
  logic [31:0]      tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;
  logic             frameEnd;
  logic [7:0][31:0] cubePts;
  logic             cubeValid;
  logic             busy;
  logic             err;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  cube_projector dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(areset),
    .s00_axis_tdata (tdata),
    .s00_axis_tvalid(tvalid),
    .s00_axis_tlast (tlast),
    .s00_axis_tready(tready),
    .frame_end      (frameEnd),
    .cube_pts       (cubePts),
    .cube_valid     (cubeValid),
    .busy           (busy),
    .err            (err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the whole simulation.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Pinhole projection of one axis: pixel = c + trunc(f*coord/z), saturated
  // far outside the image, then clamped to [0, maxv-1].
  function automatic logic [15:0] projAxis(int coord, int z, int f, int c, int maxv);
    longint q;
    longint v;
    q = (longint'(f) * longint'(coord)) / longint'(z);
    if (q >= 1048576) q = 1048576;
    else if (q <= -1048576) q = -1048576;
    v = c + q;
    if (v < 0) v = 0;
    if (v > maxv - 1) v = maxv - 1;
    return 16'(v);
  endfunction

  // Expected outcome of a complete, well-framed cube.
  function automatic exp_t expectCube(cube_t c);
    exp_t e;
    e.isErr = 1'b0;
    e.pts   = '0;
    for (int v = 0; v < 8; v++) if (c[3*v+2] < ZMIN) e.isErr = 1'b1;
    if (!e.isErr) begin
      for (int v = 0; v < 8; v++) begin
        e.pts[v] = {projAxis(c[3*v+1], c[3*v+2], FY, CY, MAX_Y),
                    projAxis(c[3*v],   c[3*v+2], FX, CX, MAX_X)};
      end
    end
    return e;
  endfunction

  function automatic int randCoord();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 40 * 65536)) - 20 * 65536;
  endfunction

  function automatic cube_t randCube();
    cube_t c;
    for (int v = 0; v < 8; v++) begin
      c[3*v]   = randCoord();
      c[3*v+1] = randCoord();
      c[3*v+2] = int'($urandom_range(32'h0000_8000, 32'h0032_0000));
    end
    return c;
  endfunction

  // Drive one beat starting at a falling edge; returns at the falling edge
  // after the handshake.
  task automatic sendBeat(input logic [31:0] d, input bit last);
    int waitCnt;
    waitCnt = 0;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
    while (!tready && waitCnt < 2000) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 2000) checkOutput("readyTimeout", {255'd0, tready}, 256'd1);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Send nBeats beats of a cube with tlast on beat lastBeat (0 = never),
  // inserting random idle cycles between beats.
  task automatic applyStimulus(input cube_t c, input int nBeats, input int lastBeat);
    for (int i = 1; i <= nBeats; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      sendBeat(c[(i-1) % 24], i == lastBeat);
    end
  endtask

  // Pulse frame_end so it is sampled on the edges-th rising edge from now.
  task automatic waitFrame(input int edges);
    repeat (edges - 1) @(negedge clk);
    frameEnd = 1'b1;
    @(negedge clk);
    frameEnd = 1'b0;
  endtask

  // Well-formed cube that should commit on a frame_end arriving on the
  // first cycle the projector can accept it (784 cycles of compute).
  task automatic commitCube(input cube_t c);
    sbq.push_back(expectCube(c));
    applyStimulus(c, 24, 24);
    waitFrame(785);
    checkOutput("commitOnFirstWaitCycle", {255'd0, busy}, 256'd0);
  endtask

  // Cube containing a too-close vertex: err must pulse 784 cycles after tlast.
  task automatic rejectCube(input cube_t c);
    int n;
    sbq.push_back(expectCube(c));
    applyStimulus(c, 24, 24);
    n = 0;
    while (!err && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rejectLatency", 256'(n), 256'd784);
    checkOutput("rejectReady", {255'd0, tready}, 256'd1);
    checkOutput("rejectKeepsValid", {255'd0, cubeValid}, 256'd1);
  endtask

  task automatic checkResetValues();
    checkOutput("resetPts", cubePts, 256'd0);
    checkOutput("resetValid", {255'd0, cubeValid}, 256'd0);
    checkOutput("resetBusy", {255'd0, busy}, 256'd0);
    checkOutput("resetErr", {255'd0, err}, 256'd0);
    checkOutput("resetReady", {255'd0, tready}, 256'd1);
  endtask

  // Monitor: pops the scoreboard on every err pulse and every commit, and
  // otherwise requires the published cube to stay put.
  initial begin
    logic [7:0][31:0] lastPts;
    bit               prevBusy;
    bit               pending;
    exp_t             e;
    lastPts  = '0;
    prevBusy = 1'b0;
    pending  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (areset) begin
        lastPts  = '0;
        prevBusy = 1'b0;
        pending  = 1'b0;
        continue;
      end
      if (pending) begin
        pending = 1'b0;
        if (sbq.size() == 0) begin
          checkOutput("unexpectedCommit", 256'd1, 256'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("commitExpected", {255'd0, e.isErr}, 256'd0);
          for (int w = 0; w < 8; w++)
            checkOutput($sformatf("cubeWord%0d", w), 256'(cubePts[w]), 256'(e.pts[w]));
          checkOutput("commitValid", {255'd0, cubeValid}, 256'd1);
          lastPts = e.pts;
        end
      end else begin
        checkOutput("ptsStable", cubePts, lastPts);
      end
      if (err) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpectedErr", 256'd1, 256'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("errExpected", {255'd0, e.isErr}, 256'd1);
        end
      end else if (prevBusy && !busy) begin
        pending = 1'b1;
      end
      prevBusy = busy;
    end
  end

  // Main stimulus sequence.
  initial begin
    cube_t c;
    cube_t c2;
    areset   = 1'b1;
    tdata    = '0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    frameEnd = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues();
    areset = 1'b0;
    @(negedge clk);

    // Cube on the optical axis; frame_end mid-compute and on the last compute
    // cycle must both be ignored, the later one in WAIT commits.
    for (int v = 0; v < 8; v++) begin
      c[3*v]   = 0;
      c[3*v+1] = 0;
      c[3*v+2] = 32'h000A_0000;
    end
    sbq.push_back(expectCube(c));
    applyStimulus(c, 24, 24);
    waitFrame(300);
    waitFrame(484);
    checkOutput("frameBeforeWaitIgnored", {255'd0, busy}, 256'd1);
    repeat (10) @(negedge clk);
    checkOutput("waitHolds", {255'd0, busy}, 256'd1);
    waitFrame(1);
    checkOutput("commitAfterWaitFrame", {255'd0, busy}, 256'd0);
    repeat (3) @(negedge clk);

    // Directed vertices: truncation, negative clamp, high clamp, saturation
    // and Z exactly at the minimum.
    c = randCube();
    c[0] = 32'h0001_0000; c[1]  = -32'sh0001_0000; c[2]  = 32'h0002_0000;
    c[3] = -32'sh0001_0000; c[4] = 32'h0000_8000;  c[5]  = 32'h0002_0000;
    c[6] = 32'h000A_0000; c[7]  = 32'h000A_0000;   c[8]  = 32'h0001_0000;
    c[9] = int'(32'h8000_0000); c[10] = 32'h7FFF_FFFF; c[11] = ZMIN;
    commitCube(c);

    // Rejected cubes: Z=0, and Z one step below the minimum.
    c = randCube();
    c[17] = 0;
    rejectCube(c);
    c = randCube();
    c[23] = ZMIN - 1;
    rejectCube(c);

    // Early tlast on beat 12, then a good cube.
    c = randCube();
    sbq.push_back('{isErr: 1'b1, pts: '0});
    applyStimulus(c, 12, 12);
    repeat (2) @(negedge clk);
    commitCube(randCube());

    // Missing tlast: 24 beats, then 5 discarded beats ending in tlast.
    c  = randCube();
    c2 = randCube();
    sbq.push_back('{isErr: 1'b1, pts: '0});
    applyStimulus(c, 24, 0);
    applyStimulus(c2, 5, 5);
    repeat (2) @(negedge clk);
    commitCube(randCube());

    // Random traffic.
    for (int i = 0; i < 3; i++) commitCube(randCube());

    // Reset during the X divide of vertex 3, then a fresh cube.
    c = randCube();
    applyStimulus(c, 24, 24);
    repeat (309) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    checkResetValues();
    areset = 1'b0;
    @(negedge clk);
    commitCube(randCube());

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", 256'(sbq.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
